// File: rtl/demux_scan_if.sv
// -----------------------------------------------------------------------------
// demux_scan_if
// Bundle of the demux_scan data-path signals.
//   master : drives mode, sel_in, in_valid, in_data; observes the outputs.
//   slave  : the demux itself; drives out_data, out_valid, cur_sel, wrap,
//            sel_err.
// Parameters N (channels) and W (bits per channel) must match the demux
// instance that uses the slave modport.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps

interface demux_scan_if #(
  parameter int N = 8,
  parameter int W = 1
);
  localparam int SEL_W = ($clog2(N) > 1) ? $clog2(N) : 1;

  logic             mode;
  logic [SEL_W-1:0] sel_in;
  logic             in_valid;
  logic [W-1:0]     in_data;
  logic [N*W-1:0]   out_data;
  logic [N-1:0]     out_valid;
  logic [SEL_W-1:0] cur_sel;
  logic             wrap;
  logic             sel_err;

  modport master (
    output mode, sel_in, in_valid, in_data,
    input  out_data, out_valid, cur_sel, wrap, sel_err
  );

  modport slave (
    input  mode, sel_in, in_valid, in_data,
    output out_data, out_valid, cur_sel, wrap, sel_err
  );
endinterface

// File: rtl/demux_scan.sv
// -----------------------------------------------------------------------------
// demux_scan
// Registered 1-to-N demultiplexer. A W-bit beat is routed to one of N output
// channels, chosen either by an external select (manual mode) or by an
// internal scan counter that dwells DWELL cycles on each channel (scan mode).
//
// Ports:
//   clk        rising-edge clock
//   reset_n    asynchronous active-low reset
//   bus        demux_scan_if.slave:
//                mode      0 = manual, 1 = scan
//                sel_in    manual channel select
//                in_valid  beat present
//                in_data   beat
//                out_data  channel k at [k*W +: W]
//                out_valid one-hot per-channel strobe
//                cur_sel   channel of the beat registered this cycle
//                wrap      pulse when the scan select wraps N-1 -> 0
//                sel_err   pulse on a manual out-of-range select with a beat
//   cnt_rd_sel / cnt_rd  (only with DEMUX_SCAN_CNT_EN defined)
//                combinational read of per-channel 8-bit saturating beat
//                counters; reads 0 for an out-of-range select.
//
// Optional feature macro: DEMUX_SCAN_CNT_EN
// -----------------------------------------------------------------------------
`timescale 1ns/1ps

module demux_scan #(
  parameter  int N     = 8,
  parameter  int W     = 1,
  parameter  int DWELL = 4,
  parameter  int HOLD  = 1,
  localparam int SEL_W = ($clog2(N) > 1) ? $clog2(N) : 1
) (
  input  logic             clk,
  input  logic             reset_n,
  demux_scan_if.slave      bus
`ifdef DEMUX_SCAN_CNT_EN
  ,
  input  logic [SEL_W-1:0] cnt_rd_sel,
  output logic [7:0]       cnt_rd
`endif
);

  localparam int DW_W = (DWELL > 1) ? $clog2(DWELL) : 1;

  // N may equal 2**SEL_W, so range checks are done one bit wider.
  localparam logic [SEL_W:0]   N_EXT      = (SEL_W+1)'(N);
  localparam logic [SEL_W-1:0] LAST_SEL   = SEL_W'(N - 1);
  localparam logic [DW_W-1:0]  DWELL_LAST = DW_W'(DWELL - 1);

  typedef enum logic {
    ST_MANUAL = 1'b0,
    ST_SCAN   = 1'b1
  } state_t;

  state_t           mode_q_r;
  logic [SEL_W-1:0] scan_sel_r;
  logic [DW_W-1:0]  dwell_cnt_r;
  logic             wrap_r;

  logic [N*W-1:0]   out_data_r;
  logic [N-1:0]     out_valid_r;
  logic [SEL_W-1:0] cur_sel_r;
  logic             sel_err_r;

  logic [SEL_W-1:0] eff_sel_s;
  logic             sel_ok_s;
  logic             accept_s;
  logic             sel_err_s;
  logic [N*W-1:0]   data_nxt_s;
  logic [N-1:0]     valid_nxt_s;

  // Effective select and beat acceptance. On the edge that enters scan mode
  // the scan position restarts, so that beat already goes to channel 0.
  always_comb begin
    eff_sel_s = {SEL_W{1'b0}};
    if (bus.mode == 1'b0) begin
      eff_sel_s = bus.sel_in;
    end else if (mode_q_r == ST_MANUAL) begin
      eff_sel_s = {SEL_W{1'b0}};
    end else begin
      eff_sel_s = scan_sel_r;
    end
    sel_ok_s  = ({1'b0, eff_sel_s} < N_EXT);
    accept_s  = bus.in_valid & sel_ok_s;
    sel_err_s = ~bus.mode & bus.in_valid & ~sel_ok_s;
  end

  // Next channel data and strobes: the selected channel takes the beat, the
  // others either hold (HOLD=1) or clear (HOLD=0).
  always_comb begin
    data_nxt_s  = {(N*W){1'b0}};
    valid_nxt_s = {N{1'b0}};
    for (int k = 0; k < N; k++) begin
      if (accept_s && (eff_sel_s == SEL_W'(k))) begin
        data_nxt_s[k*W +: W] = bus.in_data;
      end else if (HOLD != 0) begin
        data_nxt_s[k*W +: W] = out_data_r[k*W +: W];
      end else begin
        data_nxt_s[k*W +: W] = {W{1'b0}};
      end
    end
    if (accept_s) begin
      valid_nxt_s = {{(N-1){1'b0}}, 1'b1} << eff_sel_s;
    end else begin
      valid_nxt_s = {N{1'b0}};
    end
  end

  // Output data path registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      out_data_r  <= {(N*W){1'b0}};
      out_valid_r <= {N{1'b0}};
      cur_sel_r   <= {SEL_W{1'b0}};
      sel_err_r   <= 1'b0;
    end else begin
      out_data_r  <= data_nxt_s;
      out_valid_r <= valid_nxt_s;
      sel_err_r   <= sel_err_s;
      if (accept_s) begin
        cur_sel_r <= eff_sel_s;
      end else begin
        cur_sel_r <= cur_sel_r;
      end
    end
  end

  // Manual/scan state machine with dwell counter, scan select and wrap pulse.
  // Leaving scan freezes the position; re-entry always restarts at channel 0.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      mode_q_r    <= ST_MANUAL;
      scan_sel_r  <= {SEL_W{1'b0}};
      dwell_cnt_r <= {DW_W{1'b0}};
      wrap_r      <= 1'b0;
    end else begin
      case (mode_q_r)
        ST_MANUAL: begin
          wrap_r <= 1'b0;
          if (bus.mode) begin
            mode_q_r    <= ST_SCAN;
            scan_sel_r  <= {SEL_W{1'b0}};
            dwell_cnt_r <= {DW_W{1'b0}};
          end else begin
            mode_q_r <= ST_MANUAL;
          end
        end
        ST_SCAN: begin
          if (!bus.mode) begin
            mode_q_r <= ST_MANUAL;
            wrap_r   <= 1'b0;
          end else if (dwell_cnt_r == DWELL_LAST) begin
            dwell_cnt_r <= {DW_W{1'b0}};
            if (scan_sel_r == LAST_SEL) begin
              scan_sel_r <= {SEL_W{1'b0}};
              wrap_r     <= 1'b1;
            end else begin
              scan_sel_r <= scan_sel_r + SEL_W'(1);
              wrap_r     <= 1'b0;
            end
          end else begin
            dwell_cnt_r <= dwell_cnt_r + DW_W'(1);
            wrap_r      <= 1'b0;
          end
        end
        default: begin
          mode_q_r    <= ST_MANUAL;
          scan_sel_r  <= {SEL_W{1'b0}};
          dwell_cnt_r <= {DW_W{1'b0}};
          wrap_r      <= 1'b0;
        end
      endcase
    end
  end

  assign bus.out_data  = out_data_r;
  assign bus.out_valid = out_valid_r;
  assign bus.cur_sel   = cur_sel_r;
  assign bus.wrap      = wrap_r;
  assign bus.sel_err   = sel_err_r;

`ifdef DEMUX_SCAN_CNT_EN
  logic [7:0] cnt_r [N];

  // Per-channel saturating beat counters; cleared only by reset.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int k = 0; k < N; k++) begin
        cnt_r[k] <= 8'h00;
      end
    end else begin
      for (int k = 0; k < N; k++) begin
        if (valid_nxt_s[k] && (cnt_r[k] != 8'hFF)) begin
          cnt_r[k] <= cnt_r[k] + 8'h01;
        end else begin
          cnt_r[k] <= cnt_r[k];
        end
      end
    end
  end

  // Counter read port.
  always_comb begin
    cnt_rd = 8'h00;
    if ({1'b0, cnt_rd_sel} < N_EXT) begin
      cnt_rd = cnt_r[cnt_rd_sel];
    end else begin
      cnt_rd = 8'h00;
    end
  end
`endif

endmodule

// File: tb/tb_demux_scan.sv
`timescale 1ns/1ps

module tb_demux_scan;
  localparam int W  = 4;
  localparam int SW = 3;

  logic          clk = 1'b0;
  logic          reset_n;
  logic          mode;
  logic [SW-1:0] sel_in;
  logic          in_valid;
  logic [W-1:0]  in_data;

  always #5 clk = ~clk;

  // d0: N=8 DWELL=4 HOLD=1; d1: N=6 DWELL=3 HOLD=1; d2: N=5 DWELL=1 HOLD=0
  demux_scan_if #(.N(8), .W(W)) if0 ();
  demux_scan_if #(.N(6), .W(W)) if1 ();
  demux_scan_if #(.N(5), .W(W)) if2 ();

  assign if0.mode = mode;  assign if0.sel_in = sel_in;
  assign if0.in_valid = in_valid;  assign if0.in_data = in_data;
  assign if1.mode = mode;  assign if1.sel_in = sel_in;
  assign if1.in_valid = in_valid;  assign if1.in_data = in_data;
  assign if2.mode = mode;  assign if2.sel_in = sel_in;
  assign if2.in_valid = in_valid;  assign if2.in_data = in_data;

`ifdef DEMUX_SCAN_CNT_EN
  logic [SW-1:0] rd_sel;
  logic [7:0]    cnt_rd0, cnt_rd1, cnt_rd2;
`endif

  demux_scan #(.N(8), .W(W), .DWELL(4), .HOLD(1)) dut0 (
    .clk(clk), .reset_n(reset_n), .bus(if0.slave)
`ifdef DEMUX_SCAN_CNT_EN
    , .cnt_rd_sel(rd_sel), .cnt_rd(cnt_rd0)
`endif
  );
  demux_scan #(.N(6), .W(W), .DWELL(3), .HOLD(1)) dut1 (
    .clk(clk), .reset_n(reset_n), .bus(if1.slave)
`ifdef DEMUX_SCAN_CNT_EN
    , .cnt_rd_sel(rd_sel), .cnt_rd(cnt_rd1)
`endif
  );
  demux_scan #(.N(5), .W(W), .DWELL(1), .HOLD(0)) dut2 (
    .clk(clk), .reset_n(reset_n), .bus(if2.slave)
`ifdef DEMUX_SCAN_CNT_EN
    , .cnt_rd_sel(rd_sel), .cnt_rd(cnt_rd2)
`endif
  );

  // Reference model state
  int m_data [3][8];
  int m_valid [3];
  int m_cur [3];
  int m_wrap [3];
  int m_err [3];
  int m_cnt [3][8];
  int m_prev;
  int m_k;        // scan cycles elapsed since the last entry into scan mode
  int n_cmp = 0;
  int n_err = 0;

  function automatic int pn(int d);
    return (d == 0) ? 8 : ((d == 1) ? 6 : 5);
  endfunction
  function automatic int pdw(int d);
    return (d == 0) ? 4 : ((d == 1) ? 3 : 1);
  endfunction
  function automatic int ph(int d);
    return (d == 2) ? 0 : 1;
  endfunction

  task automatic model_reset;
    for (int d = 0; d < 3; d++) begin
      for (int c = 0; c < 8; c++) begin
        m_data[d][c] = 0;
        m_cnt[d][c]  = 0;
      end
      m_valid[d] = 0; m_cur[d] = 0; m_wrap[d] = 0; m_err[d] = 0;
    end
    m_prev = 0;
    m_k    = 0;
  endtask

  // One clock edge of the behavioural reference, from the current inputs.
  task automatic model_step;
    int n, dw, eff;
    bit wr;
    for (int d = 0; d < 3; d++) begin
      n  = pn(d);
      dw = pdw(d);
      if (mode == 1'b0)  eff = int'(sel_in);
      else if (m_prev == 0) eff = 0;
      else eff = (m_k / dw) % n;
      wr = in_valid && (eff < n);
      m_wrap[d] = (mode && (m_prev != 0) && (((m_k + 1) % (n * dw)) == 0)) ? 1 : 0;
      m_err[d]  = (!mode && in_valid && (eff >= n)) ? 1 : 0;
      for (int c = 0; c < n; c++) begin
        if (wr && (c == eff)) m_data[d][c] = int'(in_data);
        else if (ph(d) == 0)  m_data[d][c] = 0;
      end
      m_valid[d] = wr ? (1 << eff) : 0;
      if (wr) begin
        m_cur[d] = eff;
        if (m_cnt[d][eff] < 255) m_cnt[d][eff] = m_cnt[d][eff] + 1;
      end
    end
    if (mode) m_k = (m_prev != 0) ? (m_k + 1) : 0;
    m_prev = mode ? 1 : 0;
  endtask

  function automatic logic [63:0] pack(int d);
    logic [63:0] e;
    e = 64'd0;
    for (int c = 0; c < pn(d); c++) e[c*4 +: 4] = 4'(m_data[d][c]);
    return e;
  endfunction

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_dut(input int d, input logic [63:0] data, input logic [63:0] valid,
                           input logic [63:0] cur, input logic [63:0] wrp, input logic [63:0] err);
    check($sformatf("d%0d_data", d),  data,  pack(d));
    check($sformatf("d%0d_valid", d), valid, 64'(m_valid[d]));
    check($sformatf("d%0d_cur", d),   cur,   64'(m_cur[d]));
    check($sformatf("d%0d_wrap", d),  wrp,   64'(m_wrap[d]));
    check($sformatf("d%0d_err", d),   err,   64'(m_err[d]));
  endtask

  task automatic check_all;
    check_dut(0, 64'(if0.out_data), 64'(if0.out_valid), 64'(if0.cur_sel), 64'(if0.wrap), 64'(if0.sel_err));
    check_dut(1, 64'(if1.out_data), 64'(if1.out_valid), 64'(if1.cur_sel), 64'(if1.wrap), 64'(if1.sel_err));
    check_dut(2, 64'(if2.out_data), 64'(if2.out_valid), 64'(if2.cur_sel), 64'(if2.wrap), 64'(if2.sel_err));
  endtask

  // Advance one clock and compare every output against the model.
  task automatic cyc;
    model_step;
    @(posedge clk);
    #1;
    check_all;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int wraps;
    logic [63:0] e6;

    // Reset held low with in_valid toggling
    reset_n = 1'b0; mode = 1'b0; sel_in = 3'd0; in_valid = 1'b0; in_data = 4'h0;
    model_reset;
    #2;  check_all;
    in_valid = 1'b1; in_data = 4'hF; sel_in = 3'd1;
    #4;  check_all;                    // past an edge, still in reset
    in_valid = 1'b0;
    #4;  in_valid = 1'b1;
    #1;  check_all;
    reset_n = 1'b1;
    sel_in = 3'd2; in_data = 4'h5; in_valid = 1'b1;
    #2;  check("first_beat_latency", 64'(if0.out_valid), 64'd0);
    cyc;
    check("first_beat_valid", 64'(if0.out_valid), 64'h4);

    // Manual sweep
    for (int s = 0; s < 8; s++) begin
      mode = 1'b0; sel_in = SW'(s); in_valid = 1'b1; in_data = 4'(s + 3);
      cyc;
      check("sweep_valid", 64'(if0.out_valid), 64'(1) << s);
      if (s == 6) begin
        e6 = 64'd0;
        for (int c = 0; c < 6; c++) e6[c*4 +: 4] = 4'(c + 3);
        check("oor_err",   64'(if1.sel_err),   64'd1);
        check("oor_valid", 64'(if1.out_valid), 64'd0);
        check("oor_cur",   64'(if1.cur_sel),   64'd5);
        check("oor_data",  64'(if1.out_data),  e6);
      end
    end
    for (int c = 0; c < 8; c++)
      check($sformatf("sweep_ch%0d", c), 64'(if0.out_data[c*4 +: 4]), 64'(c + 3));
    in_valid = 1'b0;
    cyc;
    check("err_deassert", 64'(if1.sel_err), 64'd0);

    // Scan timing: enter scan without a beat, then stream
    mode = 1'b1; in_valid = 1'b0;
    cyc;
    wraps = 0;
    for (int i = 0; i < 32; i++) begin
      in_valid = 1'b1; in_data = 4'($urandom_range(0, 15));
      cyc;
      check("scan_cur", 64'(if0.cur_sel), 64'(i / 4));
      check("scan_wrap_pos", 64'(if0.wrap), (i == 31) ? 64'd1 : 64'd0);
      wraps = wraps + int'(if0.wrap);
    end
    check("scan_wrap_count", 64'(wraps), 64'd1);

    // Mode switch with HOLD=0 observation
    mode = 1'b0; in_valid = 1'b0; cyc;
    mode = 1'b1; cyc;
    for (int j = 0; j < 16; j++) begin
      in_valid = 1'b1; in_data = 4'($urandom_range(0, 15));
      cyc;
    end
    check("switch_cur3", 64'(if0.cur_sel), 64'd3);
    mode = 1'b0; sel_in = 3'd1; in_valid = 1'b1; in_data = 4'h9;
    cyc;
    check("switch_manual", 64'(if0.out_valid), 64'h2);
    in_valid = 1'b0;
    for (int j = 0; j < 2; j++) begin
      cyc;
      check("hold0_gap", 64'(if2.out_data), 64'd0);
    end
    mode = 1'b1; in_valid = 1'b1; in_data = 4'hA;
    cyc;
    check("restart_cur", 64'(if0.cur_sel), 64'd0);
    check("restart_valid", 64'(if0.out_valid), 64'h1);
    check("restart_hold0", 64'(if2.out_data), 64'hA);

    // Randomised traffic
    for (int r = 0; r < 400; r++) begin
      if ($urandom_range(0, 15) == 0) mode = ~mode;
      sel_in   = SW'($urandom_range(0, 7));
      in_valid = ($urandom_range(0, 3) != 0);
      in_data  = 4'($urandom_range(0, 15));
      cyc;
    end

    // Asynchronous reset in the middle of a scan
    mode = 1'b1; in_valid = 1'b1;
    for (int j = 0; j < 6; j++) cyc;
    #2;  reset_n = 1'b0;
    model_reset;
    #1;  check_all;
    #1;  reset_n = 1'b1;

`ifdef DEMUX_SCAN_CNT_EN
    mode = 1'b0; sel_in = 3'd2; in_valid = 1'b1; rd_sel = 3'd2;
    for (int j = 0; j < 300; j++) begin
      in_data = 4'($urandom_range(0, 15));
      cyc;
    end
    in_valid = 1'b0;
    rd_sel = 3'd2; #1;
    check("cnt_ch2", 64'(cnt_rd0), 64'(m_cnt[0][2]));
    check("cnt_ch2_sat", 64'(cnt_rd0), 64'd255);
    rd_sel = 3'd5; #1;
    check("cnt_ch5", 64'(cnt_rd0), 64'd0);
    check("cnt_d1_ch5", 64'(cnt_rd1), 64'd0);
    rd_sel = 3'd7; #1;
    check("cnt_oor", 64'(cnt_rd2), 64'd0);
`else
    mode = 1'b0; sel_in = 3'd4; in_valid = 1'b1; in_data = 4'h7;
    cyc;
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
